// File: rtl/cvxif_result_sched.sv
// cvxif_result_sched: per-lane result FIFOs shared onto one CVXIF result port by a round-robin arbiter with grant lock
module cvxif_result_sched #(
  parameter int NrLanes = 3,
  parameter int XLEN    = 32,
  parameter int IdWidth = 3,
  parameter int Depth   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [NrLanes-1:0]         lane_valid_i,
  output logic [NrLanes-1:0]         lane_ready_o,
  input  logic [NrLanes*IdWidth-1:0] lane_id_i,
  input  logic [NrLanes*XLEN-1:0]    lane_data_i,
  input  logic [NrLanes*5-1:0]       lane_rd_i,
  input  logic [NrLanes-1:0]         lane_we_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [IdWidth-1:0]         result_id_o,
  output logic [XLEN-1:0]            result_data_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o
);
  localparam int PW = $clog2(Depth);
  localparam int LW = $clog2(NrLanes);
  localparam int EW = IdWidth + XLEN + 6;
  logic [EW-1:0] mem [NrLanes][Depth];
  logic [PW-1:0] wp [NrLanes];
  logic [PW-1:0] rp [NrLanes];
  logic [PW:0] cnt [NrLanes];
  logic [NrLanes-1:0] push, pop, busy;
  logic [LW-1:0] rr_ptr, lock_lane, sel, gnt;
  logic [EW-1:0] head;
  logic lock, hs;
  // Descending scan so the lane closest to rr_ptr is the last (winning) assignment
  always_comb begin
    for (int i = 0; i < NrLanes; i++) begin
      busy[i] = cnt[i] != '0;
      lane_ready_o[i] = cnt[i] != (PW+1)'(Depth) && !flush_i;
    end
    sel = rr_ptr;
    for (int k = NrLanes - 1; k >= 0; k--)
      sel = busy[(int'(rr_ptr) + k) % NrLanes] ? LW'((int'(rr_ptr) + k) % NrLanes) : sel;
    gnt = lock ? lock_lane : sel;
    result_valid_o = |busy;
    head = mem[gnt][rp[gnt]];
    {result_id_o, result_data_o, result_rd_o, result_we_o} = result_valid_o ? head : '0;
    hs = result_valid_o && result_ready_i;
    for (int i = 0; i < NrLanes; i++) begin
      push[i] = lane_valid_i[i] && lane_ready_o[i];
      pop[i] = hs && gnt == LW'(i);
    end
  end
  always_ff @(posedge clk_i)
    for (int i = 0; i < NrLanes; i++)
      if (push[i])
        mem[i][wp[i]] <= {lane_id_i[i*IdWidth +: IdWidth], lane_data_i[i*XLEN +: XLEN],
                          lane_rd_i[i*5 +: 5], lane_we_i[i]};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int i = 0; i < NrLanes; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        cnt[i] <= '0;
      end
      rr_ptr <= '0;
      lock <= 1'b0;
      lock_lane <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NrLanes; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        cnt[i] <= '0;
      end
      rr_ptr <= '0;
      lock <= 1'b0;
      lock_lane <= '0;
    end else begin
      for (int i = 0; i < NrLanes; i++) begin
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (pop[i]) rp[i] <= rp[i] + 1'b1;
        cnt[i] <= cnt[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
      end
      if (hs) begin
        lock <= 1'b0;
        rr_ptr <= (gnt == LW'(NrLanes - 1)) ? '0 : gnt + 1'b1;
      end else if (result_valid_o) begin
        lock <= 1'b1;
        lock_lane <= gnt;
      end
    end
endmodule
